// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and RAM handshake signals around the unified memory port.
// The arbiter uses the slave view; the requesters and the RAM together use the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              dm_stall;

  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;

  logic              err_timeout;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata, ram_ack,
    output if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
           ram_req, ram_we, ram_addr, ram_wdata, err_timeout
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata, ram_ack,
    input  if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
           ram_req, ram_we, ram_addr, ram_wdata, err_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between fetch and data requesters: data wins ties until
// fetch has lost STARVE_LIMIT times in a row, and a silent RAM is aborted after MAX_WAIT cycles.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_WAIT     = 16
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_BUSY_IF = 3'd1;
  localparam logic [2:0] S_BUSY_DM = 3'd2;
  localparam logic [2:0] S_DONE_IF = 3'd3;
  localparam logic [2:0] S_DONE_DM = 3'd4;

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  logic [2:0]        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;

  logic starve_full, grant_dm, timeout_hit;

  assign starve_full = (starve_q == SW'(STARVE_LIMIT));
  // Data has priority unless fetch has been passed over too many times in a row.
  assign grant_dm    = bus.dm_req && !(bus.if_req && starve_full);
  assign timeout_hit = (MAX_WAIT != 0) && (wait_q == WW'(MAX_WAIT - 1));

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (grant_dm) begin
          state_d     = S_BUSY_DM;
          ram_we_d    = bus.dm_we;
          ram_addr_d  = bus.dm_addr;
          ram_wdata_d = bus.dm_wdata;
          if (bus.if_req && !starve_full) starve_d = starve_q + 1'b1;
        end else if (bus.if_req) begin
          state_d    = S_BUSY_IF;
          ram_we_d   = 1'b0;
          ram_addr_d = bus.if_addr;
          starve_d   = '0;
        end
      end
      S_BUSY_IF, S_BUSY_DM: begin
        wait_d = wait_q + 1'b1;
        if (bus.ram_ack) begin
          if (state_q == S_BUSY_IF) begin
            state_d    = S_DONE_IF;
            if_rdata_d = bus.ram_rdata;
          end else begin
            state_d = S_DONE_DM;
            if (!ram_we_q) dm_rdata_d = bus.ram_rdata;
          end
        end else if (timeout_hit) begin
          // Abort returns an all-zero word; a zero fetch word decodes as a NOP.
          err_d = 1'b1;
          if (state_q == S_BUSY_IF) begin
            state_d    = S_DONE_IF;
            if_rdata_d = '0;
          end else begin
            state_d    = S_DONE_DM;
            dm_rdata_d = '0;
          end
        end
      end
      S_DONE_IF, S_DONE_DM: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      wait_q      <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.ram_req     = (state_q == S_BUSY_IF) || (state_q == S_BUSY_DM);
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.if_ready    = (state_q == S_DONE_IF);
  assign bus.dm_ready    = (state_q == S_DONE_DM);
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign bus.if_stall    = bus.if_req && !bus.if_ready;
  assign bus.dm_stall    = bus.dm_req && !bus.dm_ready;
  assign bus.err_timeout = err_q;

  a_ram_stable: assert property (@(posedge clock) disable iff (!reset)
    (bus.ram_req && !bus.ram_ack) |=> $stable({bus.ram_we, bus.ram_addr, bus.ram_wdata}));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic,
// all continuously compared against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;
  localparam int MW  = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM), .MAX_WAIT(MW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  // RAM behaviour: responds after a chosen number of BUSY cycles; random data otherwise.
  logic [31:0] mem [logic [31:0]];
  int ack_dly_fix = 0;
  bit ack_rand    = 1'b0;
  bit ack_en      = 1'b1;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  initial begin
    int a_cnt, a_dly;
    a_cnt = 0;
    a_dly = 0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    forever begin
      cyc();
      if (!bus.ram_req) begin
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = $urandom;
        a_cnt = 0;
      end else begin
        if (a_cnt == 0)
          a_dly = !ack_rand ? ack_dly_fix :
                  ($urandom_range(0, 19) == 0) ? 40 : int'($urandom_range(0, 3));
        if (ack_en && a_cnt == a_dly) begin
          bus.ram_ack   = 1'b1;
          bus.ram_rdata = rd(bus.ram_addr);
          if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
        end else begin
          bus.ram_ack   = 1'b0;
          bus.ram_rdata = $urandom;
        end
        a_cnt++;
      end
    end
  end

  // Transaction-level model: one outstanding access record, its elapsed RAM cycles,
  // and a one-cycle completion pulse; outputs derived from those facts.
  bit          chk_en = 1'b0;
  bit          m_act = 1'b0, m_who_dm = 1'b0, m_done_if = 1'b0, m_done_dm = 1'b0, m_err = 1'b0;
  bit          m_we = 1'b0;
  int          m_wait = 0, m_starve = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_dm_rd = '0;

  always @(negedge clock) begin
    if (chk_en) begin
      chk("ram_req",     bus.ram_req,     32'(m_act));
      chk("ram_we",      bus.ram_we,      32'(m_we));
      chk("ram_addr",    bus.ram_addr,    m_addr);
      chk("ram_wdata",   bus.ram_wdata,   m_wdata);
      chk("if_ready",    bus.if_ready,    32'(m_done_if));
      chk("dm_ready",    bus.dm_ready,    32'(m_done_dm));
      chk("if_rdata",    bus.if_rdata,    m_if_rd);
      chk("dm_rdata",    bus.dm_rdata,    m_dm_rd);
      chk("if_stall",    bus.if_stall,    32'(bus.if_req && !m_done_if));
      chk("dm_stall",    bus.dm_stall,    32'(bus.dm_req && !m_done_dm));
      chk("err_timeout", bus.err_timeout, 32'(m_err));
    end
    if (!reset) begin
      m_act = 0; m_who_dm = 0; m_done_if = 0; m_done_dm = 0; m_err = 0; m_we = 0;
      m_wait = 0; m_starve = 0; m_addr = '0; m_wdata = '0; m_if_rd = '0; m_dm_rd = '0;
    end else if (m_done_if || m_done_dm) begin
      m_done_if = 0;
      m_done_dm = 0;
    end else if (m_act) begin
      m_wait++;
      if (bus.ram_ack) begin
        m_act = 0;
        if (!m_who_dm) begin m_if_rd = bus.ram_rdata; m_done_if = 1; end
        else begin if (!m_we) m_dm_rd = bus.ram_rdata; m_done_dm = 1; end
      end else if (MW != 0 && m_wait == MW) begin
        m_act = 0;
        m_err = 1;
        if (!m_who_dm) begin m_if_rd = '0; m_done_if = 1; end
        else begin m_dm_rd = '0; m_done_dm = 1; end
      end
    end else if (bus.dm_req && !(bus.if_req && m_starve == LIM)) begin
      m_act = 1; m_who_dm = 1; m_wait = 0;
      m_addr = bus.dm_addr; m_we = bus.dm_we; m_wdata = bus.dm_wdata;
      if (bus.if_req && m_starve < LIM) m_starve++;
    end else if (bus.if_req) begin
      m_act = 1; m_who_dm = 0; m_wait = 0;
      m_addr = bus.if_addr; m_we = 0;
      m_starve = 0;
    end
  end

  // Watches both ready pulses for ncyc cycles, dropping each request the cycle after it completes.
  task automatic serve(input int ncyc, output int t_if, output int t_dm,
                       output logic [31:0] rif, output logic [31:0] rdm, output bit we_seen);
    t_if = -1; t_dm = -1; rif = '0; rdm = '0; we_seen = 0;
    for (int c = 1; c <= ncyc; c++) begin
      smp();
      if (bus.ram_req && bus.ram_we) we_seen = 1;
      if (bus.if_ready && t_if < 0) begin t_if = c; rif = bus.if_rdata; end
      if (bus.dm_ready && t_dm < 0) begin t_dm = c; rdm = bus.dm_rdata; end
      cyc();
      if (t_if == c) bus.if_req = 1'b0;
      if (t_dm == c) bus.dm_req = 1'b0;
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, required finish before %0t", $time);
    $fatal(1);
  end

  int          t_if, t_dm, order, n_ev, n_dm;
  logic [31:0] rif, rdm;
  bit          we_seen, r_if, r_dm;

  initial begin
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
    mem[32'h10] = 32'h2108000A;
    mem[32'h40] = 32'h12345678;

    repeat (3) @(posedge clock);
    #1;
    chk_en = 1'b1;
    smp();
    chk("rst_ram_req", bus.ram_req, 0);
    chk("rst_ready",   {bus.if_ready, bus.dm_ready}, 0);
    chk("rst_err",     bus.err_timeout, 0);
    chk("rst_rdata",   bus.if_rdata | bus.dm_rdata, 0);

    // T1: single fetch, immediate ack
    cyc(); reset = 1'b1;
    cyc(); bus.if_req = 1; bus.if_addr = 32'h10;
    smp(); chk("t1_stall_c1", bus.if_stall, 1); chk("t1_req_c1", bus.ram_req, 0);
    cyc(); smp();
    chk("t1_stall_c2", bus.if_stall, 1); chk("t1_req_c2", bus.ram_req, 1);
    chk("t1_addr_c2", bus.ram_addr, 32'h10); chk("t1_we_c2", bus.ram_we, 0);
    cyc(); smp();
    chk("t1_ready_c3", bus.if_ready, 1); chk("t1_rdata", bus.if_rdata, 32'h2108000A);
    chk("t1_stall_c3", bus.if_stall, 0);
    cyc(); bus.if_req = 0;

    // T2: simultaneous requests, data load first
    bus.if_req = 1; bus.if_addr = 32'h20;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h40;
    serve(12, t_if, t_dm, rif, rdm, we_seen);
    chk("t2_dm_cycle", t_dm, 3); chk("t2_if_cycle", t_if, 6);
    chk("t2_we_seen", 32'(we_seen), 0); chk("t2_dm_rdata", rdm, 32'h12345678);

    // T3: store with two RAM wait cycles
    ack_dly_fix = 2;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h44; bus.dm_wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 5; c++) begin
      smp();
      if (c >= 2 && c <= 4) begin
        chk("t3_req", bus.ram_req, 1); chk("t3_we", bus.ram_we, 1);
        chk("t3_addr", bus.ram_addr, 32'h44); chk("t3_wdata", bus.ram_wdata, 32'hDEADBEEF);
        chk("t3_ready_early", bus.dm_ready, 0);
      end
      if (c == 5) begin
        chk("t3_ready", bus.dm_ready, 1); chk("t3_rdata_kept", bus.dm_rdata, 32'h12345678);
      end
      cyc();
    end
    bus.dm_req = 0; bus.dm_we = 0;
    chk("t3_mem", mem[32'h44], 32'hDEADBEEF);

    // T4: fetch held against five back-to-back data accesses
    ack_dly_fix = 0;
    bus.if_req = 1; bus.if_addr = 32'h80;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h100;
    order = 0; n_ev = 0; n_dm = 0;
    for (int c = 0; c < 60 && n_ev < 6; c++) begin
      smp(); r_if = bus.if_ready; r_dm = bus.dm_ready;
      if (r_dm) begin order = order * 2 + 1; n_ev++; n_dm++; end
      if (r_if) begin order = order * 2; n_ev++; end
      cyc();
      if (r_if) bus.if_req = 0;
      if (r_dm) begin if (n_dm == 5) bus.dm_req = 0; else bus.dm_addr += 4; end
    end
    bus.if_req = 0; bus.dm_req = 0;
    chk("t4_events", n_ev, 6); chk("t4_order", order, 32'b111101);

    // T5: RAM never acks
    ack_en = 0;
    bus.if_req = 1; bus.if_addr = 32'h200;
    serve(20, t_if, t_dm, rif, rdm, we_seen);
    chk("t5_if_cycle", t_if, 18); chk("t5_rdata", rif, 0); chk("t5_err", bus.err_timeout, 1);
    ack_en = 1;
    bus.if_req = 1; bus.if_addr = 32'h10;
    serve(6, t_if, t_dm, rif, rdm, we_seen);
    chk("t5_after_cycle", t_if, 3); chk("t5_after_rdata", rif, 32'h2108000A);
    chk("t5_err_sticky", bus.err_timeout, 1);

    // T6: reset in the middle of a data access
    ack_dly_fix = 5;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h40;
    smp(); cyc();
    smp(); chk("t6_busy", bus.ram_req, 1);
    cyc(); reset = 0; bus.dm_req = 0;
    smp(); cyc(); reset = 1;
    smp();
    chk("t6_req_low", bus.ram_req, 0); chk("t6_no_ready", bus.dm_ready, 0);
    chk("t6_err_clr", bus.err_timeout, 0);
    cyc(); smp(); chk("t6_no_ready2", bus.dm_ready | bus.ram_req, 0);
    cyc();
    ack_dly_fix = 0;
    bus.if_req = 1; bus.if_addr = 32'h10;
    serve(6, t_if, t_dm, rif, rdm, we_seen);
    chk("t6_fetch_cycle", t_if, 3); chk("t6_fetch_rdata", rif, 32'h2108000A);

    // T7: data request dropped while the access is in flight
    ack_dly_fix = 2;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h40;
    smp(); cyc(); bus.dm_req = 0;
    serve(6, t_if, t_dm, rif, rdm, we_seen);
    chk("t7_dm_cycle", t_dm, 4); chk("t7_rdata", rdm, 32'h12345678);

    // Random traffic with random RAM latency, occasional timeouts and resets
    ack_rand = 1;
    for (int c = 0; c < 4000; c++) begin
      smp(); r_if = bus.if_ready; r_dm = bus.dm_ready;
      cyc();
      if (reset == 0) reset = 1;
      else if ($urandom_range(0, 599) == 0) begin
        reset = 0; bus.if_req = 0; bus.dm_req = 0;
      end
      if (reset) begin
        if (bus.if_req) begin
          if (r_if) begin
            if ($urandom_range(0, 1) == 0) bus.if_addr = rnd_addr(); else bus.if_req = 0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          bus.if_req = 1; bus.if_addr = rnd_addr();
        end
        if (bus.dm_req) begin
          if (r_dm) begin
            if ($urandom_range(0, 1) == 0) begin
              bus.dm_addr = rnd_addr(); bus.dm_we = 1'($urandom_range(0, 1)); bus.dm_wdata = $urandom;
            end else bus.dm_req = 0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          bus.dm_req = 1; bus.dm_addr = rnd_addr();
          bus.dm_we = 1'($urandom_range(0, 1)); bus.dm_wdata = $urandom;
        end
      end
    end
    bus.if_req = 0; bus.dm_req = 0; reset = 1;
    repeat (30) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
